// File: rtl/reg_file_pkg.sv
// Shared processor constants for the architectural register file:
// default geometry, the hardwired-zero index and the register index type.
package reg_file_pkg;

  localparam int unsigned RF_WIDTH    = 64;
  localparam int unsigned RF_DEPTH    = 32;
  localparam int unsigned RF_ZERO_REG = 31;
  localparam int unsigned RF_ADDR_W   = 5;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;

  // True when an index names a real, writable register (not XZR, not past DEPTH).
  function automatic logic rfWritable(input rf_addr_t addr,
                                      input int unsigned depth,
                                      input int unsigned zeroReg);
    return (32'(addr) < depth) && (32'(addr) != zeroReg);
  endfunction

endpackage

// File: rtl/reg_file_word.sv
// One register of the file: WIDTH-bit storage with a load enable and an
// asynchronous active-low clear.
module reg_word #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] dataQ;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dataQ <= '0;
    end else if (ld_i) begin
      dataQ <= d_i;
    end
  end

  assign q_o = dataQ;

endmodule

// File: rtl/reg_file.sv
// Architectural register file: one write port, two registered read ports with
// a shared capture strobe, write-to-read bypass and a hardwired zero register.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int unsigned WIDTH    = RF_WIDTH,
  parameter int unsigned DEPTH    = RF_DEPTH,
  parameter int unsigned ZERO_REG = RF_ZERO_REG
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 WR_EN,
  input  logic [RF_ADDR_W-1:0] WR_ADDR,
  input  logic [WIDTH-1:0]     WR_DATA,
  input  logic                 RD_EN,
  input  logic [RF_ADDR_W-1:0] RA_ADDR,
  input  logic [RF_ADDR_W-1:0] RB_ADDR,
  output logic [WIDTH-1:0]     RA_DATA,
  output logic [WIDTH-1:0]     RB_DATA,
  output logic                 RD_VALID
);

  localparam logic [RF_ADDR_W-1:0] ZeroAddr = RF_ADDR_W'(ZERO_REG);

  logic [WIDTH-1:0] words [DEPTH];
  logic             wrAllowed;
  logic             bypassA;
  logic             bypassB;
  logic [WIDTH-1:0] raD, raQ;
  logic [WIDTH-1:0] rbD, rbQ;
  logic             validQ;

  assign wrAllowed = WR_EN && rfWritable(WR_ADDR, DEPTH, ZERO_REG);

  // The zero register still gets a storage word, but its load is tied off.
  for (genvar g = 0; g < DEPTH; g++) begin : gWord
    localparam bit Writable = (g != ZERO_REG);
    logic wordLd;

    assign wordLd = Writable && wrAllowed && (WR_ADDR == RF_ADDR_W'(g));

    reg_word #(.WIDTH(WIDTH)) uWord (
      .clk_i  (CLK),
      .rst_ni (RST_N),
      .ld_i   (wordLd),
      .d_i    (WR_DATA),
      .q_o    (words[g])
    );
  end

  assign bypassA = wrAllowed && (WR_ADDR == RA_ADDR);
  assign bypassB = wrAllowed && (WR_ADDR == RB_ADDR);

  // Out-of-range indices fall through the loop and read as zero.
  always_comb begin
    raD = '0;
    rbD = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (RA_ADDR == RF_ADDR_W'(i)) raD = words[i];
      if (RB_ADDR == RF_ADDR_W'(i)) rbD = words[i];
    end
    if (bypassA) raD = WR_DATA;
    if (bypassB) rbD = WR_DATA;
    if (RA_ADDR == ZeroAddr) raD = '0;
    if (RB_ADDR == ZeroAddr) rbD = '0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      raQ    <= '0;
      rbQ    <= '0;
      validQ <= 1'b0;
    end else begin
      validQ <= RD_EN;
      if (RD_EN) begin
        raQ <= raD;
        rbQ <= rbD;
      end
    end
  end

  assign RA_DATA  = raQ;
  assign RB_DATA  = rbQ;
  assign RD_VALID = validQ;

endmodule
